sobel_v_window_ctrl: RTL
========================

SOBEL_V_WINDOW_CTRL -- requirements
Module: sobel_v_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 64, image width in pixels (range 3..1024).
REQ-002 Parameter IMG_H, default 64, image height in pixels (range 3..1024).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse that begins a frame.
REQ-006 in_valid  in  1  in_pix holds a valid raster-order pixel.
REQ-007 in_pix  in  8  input pixel, row-major, unsigned.
REQ-008 in_ready  out  1  block accepts a pixel this cycle.
REQ-009 p1, p3, p4, p6, p7, p9  out  8 each  kernel window taps: p1/p3 top-left/right, p4/p6 middle-left/right, p7/p9 bottom-left/right.
REQ-010 kern_y  in  8  combinational vertical-Sobel kernel result for the current taps.
REQ-011 out_valid  out  1  out_pix holds a valid result.
REQ-012 out_pix  out  8  registered kernel result.
REQ-013 out_last  out  1  marks the final result of the frame.
REQ-014 busy  out  1  frame in progress.
REQ-015 done  out  1  one-cycle pulse on frame completion.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start; RUN->DONE on the cycle out_last is asserted; DONE->IDLE unconditionally after one cycle.
REQ-018 start in RUN or DONE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in RUN while the input pixel count is below IMG_W*IMG_H; a pixel is accepted when in_valid and in_ready are both 1.
REQ-020 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance per accepted pixel; col wraps to 0 and row increments at col=IMG_W-1.
REQ-021 Two line buffers of IMG_W x 8 bits SHALL hold rows row-1 and row-2; each accepted pixel shifts the column through: line buffer 1 output -> line buffer 2, in_pix -> line buffer 1.
REQ-022 A 3x3 window register SHALL shift left by one column per accepted pixel; the new right column is {row-2, row-1, row} values at column col.
REQ-023 Taps SHALL be driven from the window registers: p1/p4/p7 = left column, p3/p6/p9 = right column; the centre column is not output.
REQ-024 win_valid (internal) SHALL be registered 1 in the cycle after acceptance of a pixel with row>=2 and col>=2, else 0; no window spans a row wrap.
REQ-025 In the cycle after win_valid=1, out_valid SHALL be 1 and out_pix SHALL equal kern_y sampled while win_valid was 1; total latency is 2 cycles from acceptance.
REQ-026 Exactly (IMG_W-2)*(IMG_H-2) results SHALL be produced per frame; out_last SHALL be 1 with the result of pixel (IMG_H-1, IMG_W-1) only.
REQ-027 Cycles without acceptance (in_valid=0) SHALL hold window, counters and taps and produce no win_valid.
REQ-028 The output has no backpressure; each result is presented for exactly one cycle.
REQ-029 busy SHALL be 1 in RUN and DONE; done SHALL be 1 only in DONE.
REQ-030 Line-buffer contents are not cleared between frames; the first two rows of each frame overwrite them before any window is valid.

Reset
REQ-031 With rst=1 at a clock edge: state=IDLE, row=col=0, window registers=0, win_valid=0.
REQ-032 Outputs after reset: in_ready=0, out_valid=0, out_pix=0, out_last=0, busy=0, done=0, all taps=0.
REQ-033 rst SHALL take priority over start and in_valid in the same cycle; reset mid-frame discards the partial frame, and no further results are emitted.

Verification
REQ-034 IMG_W=IMG_H=4, ramp in_pix=4*row+col, bench model kern_y=p9 -> first out_valid 2 cycles after accepting pixel 10; taps at that window p1=0,p3=2,p4=4,p6=6,p7=8,p9=10; results 10,11,14,15; out_last on 15; done one cycle later.
REQ-035 Same frame, in_valid deasserted 3 cycles after every accepted pixel -> identical result sequence, 4 results, no spurious out_valid.
REQ-036 start pulsed again mid-frame -> ignored; result count stays 4; busy stays 1 until done.
REQ-037 rst asserted after 9 accepted pixels -> next cycle in_ready=0, busy=0, out_valid=0; a new start with a full frame yields the correct 4 results.
REQ-038 IMG_W=IMG_H=3, constant pixel 200, kern_y=p1 -> exactly one result 200 with out_last=1, followed by done=1.
REQ-039 Back-to-back frames (start in the cycle after done) -> second frame results are unaffected by stale line-buffer data.

Source files
------------

// File: rtl/sobel_v_window_ctrl.sv
// Raster-order 3x3 window controller for a vertical Sobel kernel: two line
// buffers, a shifting window, tap outputs and a registered result stage.
module sobel_v_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  output logic       in_ready,
  output logic [7:0] p1,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p9,
  input  logic [7:0] kern_y,
  output logic       out_valid,
  output logic [7:0] out_pix,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NW   = $clog2(NPIX + 1);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);
  localparam logic [NW-1:0] NPIX_C  = NW'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [NW-1:0] cnt_q, cnt_d;

  // win_q[r][c]: r=0 is row-2, r=2 is the current row; c=0 is the left column
  logic [2:0][2:0][7:0] win_q, win_d;
  logic [7:0] lb1_q [IMG_W];
  logic [7:0] lb2_q [IMG_W];

  logic       win_valid_q, win_last_q;
  logic       out_valid_q, out_last_q;
  logic [7:0] out_pix_q;
  logic       accept_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (out_last_q) state_d = S_DONE;
        else            state_d = S_RUN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (cnt_q < NPIX_C);
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
      end
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // Raster position and accepted-pixel count
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start) begin
      col_d = '0;
      row_d = '0;
      cnt_d = '0;
    end else if (accept_s) begin
      cnt_d = cnt_q + NW'(1);
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) row_d = '0;
        else                  row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
      cnt_d = cnt_q;
    end
  end

  // Window shifts left; the new right column is {row-2, row-1, row} at col
  always_comb begin
    win_d = win_q;
    if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = in_pix;
    end else begin
      win_d = win_q;
    end
  end

  // Counters, window and result pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= 8'd0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      win_valid_q <= accept_s && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      win_last_q  <= accept_s && (row_q == ROW_MAX) && (col_q == COL_MAX);
      out_valid_q <= win_valid_q;
      out_last_q  <= win_valid_q & win_last_q;
      if (win_valid_q) out_pix_q <= kern_y;
      else             out_pix_q <= out_pix_q;
    end
  end

  // Line buffers are never cleared; rows 0 and 1 of a frame refill them
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_pix;
    end
  end

  assign p1 = win_q[0][0];
  assign p3 = win_q[0][2];
  assign p4 = win_q[1][0];
  assign p6 = win_q[1][2];
  assign p7 = win_q[2][0];
  assign p9 = win_q[2][2];

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

endmodule
